// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_sequencer and fetch_skid.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } fetch_state_t;

endpackage

// File: rtl/adder.sv
// Plain N-bit unsigned adder; the carry-out is dropped, so sums wrap.
module adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that decode could not take.
// Flush beats load, and load beats drain.
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [N-1:0]       in_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       pc,
    output logic               full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: PC, imem req/ack sequencing, IF/ID register.
// Define FETCH_EXC_EN to add the exc_F redirect to EXC_VECTOR.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int           N          = 64,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter logic [N-1:0] EXC_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [N-1:0]       PCBranch_F,
    input  logic               stall_D,
`ifdef FETCH_EXC_EN
    input  logic               exc_F,
`endif
    output logic               imem_req,
    output logic [N-1:0]       imem_addr_F,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_D,
    output logic [N-1:0]       pc_D,
    output logic               valid_D
);

`ifdef FETCH_EXC_EN
`else
    logic exc_F;
    assign exc_F = 1'b0;
`endif

    fetch_state_t state, state_nxt;

    logic [N-1:0]       pc;
    logic [N-1:0]       pc_inc;
    logic [N-1:0]       redir_pc;
    logic [N-1:0]       redir_tgt;
    logic               redir_pend;
    logic               redir;
    logic               if_free;
    logic               accept;
    logic               take_direct;
    logic               skid_load;
    logic               skid_drain;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [N-1:0]       skid_pc;

    // An exception wins over a branch redirect in the same cycle.
    assign redir       = PCSrc_F | exc_F;
    assign redir_tgt   = exc_F ? EXC_VECTOR : PCBranch_F;
    assign if_free     = !valid_D || !stall_D;
    assign accept      = (state == S_FETCH) && imem_ack
                         && !redir && !redir_pend;
    assign take_direct = accept && if_free;
    assign skid_load   = accept && !if_free;
    assign skid_drain  = (state == S_HOLD) && skid_full
                         && !redir && !stall_D;
    assign imem_addr_F = pc;

    adder #(.N(N)) u_inc (
        .a (pc),
        .b (N'(PC_INC)),
        .y (pc_inc)
    );

    fetch_skid #(.N(N)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .drain    (skid_drain),
        .flush    (redir),
        .in_instr (imem_rdata),
        .in_pc    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (skid_load) state_nxt = S_HOLD;
            S_HOLD:  if (redir || !stall_D) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == S_FETCH);
    end

    // The address must hold while a request is outstanding, so a redirect
    // seen mid-request is parked until the ack arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redir || redir_pend) begin
                            pc         <= redir ? redir_tgt : redir_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            pc <= pc_inc;
                        end
                    end else if (redir) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= redir_tgt;
                    end
                end
                default: if (redir) pc <= redir_tgt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_D <= '0;
            pc_D    <= '0;
            valid_D <= 1'b0;
        end else if (redir) begin
            valid_D <= 1'b0;
        end else if (skid_drain) begin
            instr_D <= skid_instr;
            pc_D    <= skid_pc;
            valid_D <= 1'b1;
        end else if (take_direct) begin
            instr_D <= imem_rdata;
            pc_D    <= pc;
            valid_D <= 1'b1;
        end else if (!stall_D) begin
            valid_D <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic.
module tb_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [63:0] EXC_V  = 64'h80;
    localparam logic [63:0] NO_ADDR = 64'hFFFF_FFFF_FFFF_FFF1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic        stall_D = 1'b0;
    logic        exc_F = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr_F;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .N          (64),
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_V)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc_F     (PCSrc_F),
        .PCBranch_F  (PCBranch_F),
        .stall_D     (stall_D),
`ifdef FETCH_EXC_EN
        .exc_F       (exc_F),
`endif
        .imem_req    (imem_req),
        .imem_addr_F (imem_addr_F),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .valid_D     (valid_D)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h9E37_79B9 ^ {a[15:0], 16'h0};
    endfunction

    function void check(string nm, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
                     $time);
        end
    endfunction

    // Reference model: fetch mode, PC, parked redirect, skid queue, IF/ID.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } slot_t;

    int          m_mode;     // 0 waiting to start, 1 fetching, 2 holding
    logic [63:0] m_pc;
    bit          m_pend;
    logic [63:0] m_rpc;
    slot_t       m_skid[$];
    bit          m_vld;
    logic [31:0] m_instr;
    logic [63:0] m_pcd;

    task automatic model_step();
        bit          rd;
        bit          free;
        logic [63:0] tgt;
        slot_t       s;
        if (reset) begin
            m_mode = 0; m_pc = RST_PC; m_pend = 0; m_skid.delete();
            m_vld = 0; m_instr = '0; m_pcd = '0;
            return;
        end
        rd   = PCSrc_F || exc_F;
        tgt  = exc_F ? EXC_V : PCBranch_F;
        free = !m_vld || !stall_D;
        if (m_mode == 0) begin
            m_mode = 1;
            if (rd) m_pc = tgt;
            m_vld = rd ? 1'b0 : (m_vld && stall_D);
        end else if (m_mode == 1) begin
            if (imem_ack && (rd || m_pend)) begin
                m_pc = rd ? tgt : m_rpc;
                m_pend = 0;
                m_vld = rd ? 1'b0 : (m_vld && stall_D);
            end else if (imem_ack && free) begin
                m_instr = imem_rdata; m_pcd = m_pc; m_vld = 1;
                m_pc = m_pc + 64'd4;
            end else if (imem_ack) begin
                s.instr = imem_rdata; s.pc = m_pc;
                m_skid.push_back(s);
                m_pc = m_pc + 64'd4;
                m_mode = 2;
            end else begin
                if (rd) begin m_pend = 1; m_rpc = tgt; end
                m_vld = rd ? 1'b0 : (m_vld && stall_D);
            end
        end else begin
            if (rd) begin
                m_skid.delete(); m_vld = 0; m_pc = tgt; m_mode = 1;
            end else if (!stall_D && m_skid.size() > 0) begin
                s = m_skid.pop_front();
                m_instr = s.instr; m_pcd = s.pc; m_vld = 1; m_mode = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req", {63'b0, imem_req}, {63'b0, m_mode == 1});
            check("imem_addr_F", imem_addr_F, m_pc);
            check("valid_D", {63'b0, valid_D}, {63'b0, m_vld});
            check("pc_D", pc_D, m_pcd);
            check("instr_D", {32'b0, instr_D}, {32'b0, m_instr});
        end
    end

    // Memory responder: each new request gets a latency, then one ack.
    bit          lat_rand = 1'b0;
    logic [63:0] slow_addr = NO_ADDR;
    int          slow_lat = 0;
    bit          busy = 1'b0;
    int          cnt = 0;

    task automatic mem_respond();
        if (imem_req === 1'b1) begin
            if (!busy) begin
                busy = 1'b1;
                if (lat_rand) cnt = $urandom_range(0, 3);
                else cnt = (imem_addr_F == slow_addr) ? slow_lat : 0;
            end
            imem_ack = (cnt == 0);
            imem_rdata = mem_word(imem_addr_F);
            if (cnt == 0) busy = 1'b0;
            else cnt--;
        end else begin
            busy = 1'b0;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        mem_respond();
    endtask

    task automatic do_reset();
        reset = 1'b1; PCSrc_F = 1'b0; stall_D = 1'b0; exc_F = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_addr(input logic [63:0] a);
        int n;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr_F === a) && n < 40) begin
            tick();
            n++;
        end
        check("wait_addr_timeout", {63'b0, n < 40}, 64'd1);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Zero-wait memory, no stalls: one instruction per cycle
        check("rst_req", {63'b0, imem_req}, 64'd0);
        check("rst_addr", imem_addr_F, RST_PC);
        check("rst_valid", {63'b0, valid_D}, 64'd0);
        check("rst_pc_D", pc_D, 64'd0);
        tick();
        check("first_addr", imem_addr_F, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem_addr_F, 64'(4 * i));
            check("seq_req", {63'b0, imem_req}, 64'd1);
            tick();
            check("seq_pc_D", pc_D, 64'(4 * i));
            check("seq_valid", {63'b0, valid_D}, 64'd1);
            check("seq_instr", {32'b0, instr_D},
                  {32'b0, mem_word(64'(4 * i))});
        end

        // Ack delayed three cycles at address 8
        do_reset();
        slow_addr = 64'h8; slow_lat = 3;
        tick();
        wait_addr(64'h8);
        for (int k = 0; k < 4; k++) begin
            check("slow_hold_addr", imem_addr_F, 64'h8);
            check("slow_hold_req", {63'b0, imem_req}, 64'd1);
            tick();
        end
        check("slow_pc_D", pc_D, 64'h8);
        check("slow_valid", {63'b0, valid_D}, 64'd1);
        slow_addr = NO_ADDR;

        // Stall for four cycles while 0x10 is fetched
        do_reset();
        tick();
        wait_addr(64'h10);
        stall_D = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_req", {63'b0, imem_req}, 64'd0);
            check("hold_pc_D", pc_D, 64'hC);
        end
        stall_D = 1'b0;
        tick();
        check("drain_pc_D", pc_D, 64'h10);
        check("drain_valid", {63'b0, valid_D}, 64'd1);
        check("drain_addr", imem_addr_F, 64'h14);
        tick();
        check("after_drain_pc_D", pc_D, 64'h14);

        // Redirect while the ack for 0x20 is outstanding
        do_reset();
        slow_addr = 64'h20; slow_lat = 3;
        tick();
        wait_addr(64'h20);
        PCSrc_F = 1'b1; PCBranch_F = 64'h100;
        tick();
        PCSrc_F = 1'b0;
        check("redir_squash", {63'b0, valid_D}, 64'd0);
        check("redir_addr_held", imem_addr_F, 64'h20);
        for (int k = 0; k < 10 && imem_addr_F == 64'h20; k++) tick();
        check("redir_new_addr", imem_addr_F, 64'h100);
        check("redir_discard", {63'b0, valid_D}, 64'd0);
        tick();
        check("redir_pc_D", pc_D, 64'h100);
        check("redir_instr", {32'b0, instr_D}, {32'b0, mem_word(64'h100)});
        slow_addr = NO_ADDR;

        // Reset mid-wait
        do_reset();
        slow_addr = 64'h8; slow_lat = 3;
        tick();
        wait_addr(64'h8);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_req", {63'b0, imem_req}, 64'd0);
        check("rstw_addr", imem_addr_F, RST_PC);
        check("rstw_valid", {63'b0, valid_D}, 64'd0);
        check("rstw_pc_D", pc_D, 64'd0);
        check("rstw_instr", {32'b0, instr_D}, 64'd0);
        tick();
        check("rstw_first", imem_addr_F, RST_PC);
        slow_addr = NO_ADDR;

        // Reset while holding
        wait_addr(64'h10);
        stall_D = 1'b1;
        tick();
        check("rsth_inhold", {63'b0, imem_req}, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; stall_D = 1'b0;
        check("rsth_valid", {63'b0, valid_D}, 64'd0);
        check("rsth_pc_D", pc_D, 64'd0);
        tick();
        check("rsth_first", imem_addr_F, RST_PC);
        check("rsth_req", {63'b0, imem_req}, 64'd1);

        // PC wraps modulo 2^64
        PCSrc_F = 1'b1; PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PCSrc_F = 1'b0;
        check("wrap_tgt", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr_F, 64'h0);
        check("wrap_pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef FETCH_EXC_EN
        // Exception wins over a simultaneous branch
        exc_F = 1'b1; PCSrc_F = 1'b1; PCBranch_F = 64'h200;
        tick();
        exc_F = 1'b0; PCSrc_F = 1'b0;
        check("exc_prio", imem_addr_F, 64'h80);
`endif

        // Randomized traffic
        lat_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 99) == 0);
            stall_D = ($urandom_range(0, 9) < 3);
            PCSrc_F = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 19) == 0)
                PCBranch_F = 64'hFFFF_FFFF_FFFF_FFF8;
            else
                PCBranch_F = {54'b0, 8'($urandom_range(0, 255)), 2'b00};
`ifdef FETCH_EXC_EN
            exc_F = ($urandom_range(0, 99) < 3);
`endif
        end
        reset = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the instruction-fetch stage: owns the program counter, sequences requests to a variable-latency instruction memory over a req/ack handshake, and delivers fetched instructions into the IF/ID register with a valid bit. It sits between the branch-resolution logic (`PCSrc_F`/`PCBranch_F`) and decode (`stall_D`). It handles stalls, in-flight redirects and squashing of wrong-path instructions.

## Interface
- `N`, 64, PC/address width
- `RESET_PC`, 0, PC value fetched first after reset
- `EXC_VECTOR`, 'h0, redirect target on exception (used only with `FETCH_EXC_EN`)

- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: synchronous, active-high
- `PCSrc_F` input 1: taken branch/redirect this cycle
- `PCBranch_F` input N: redirect target, valid with `PCSrc_F`
- `stall_D` input 1: decode cannot accept a new instruction
- `imem_req` output 1: fetch request
- `imem_addr_F` output N: fetch address; stable while `imem_req`=1 and no ack
- `imem_ack` input 1: read data valid this cycle; may arrive in the same cycle as `imem_req`
- `imem_rdata` input 32: instruction word
- `instr_D` output 32: IF/ID instruction
- `pc_D` output N: IF/ID PC
- `valid_D` output 1: IF/ID holds a live instruction
- `exc_F` input 1: exception redirect (present only with `FETCH_EXC_EN`)

## Operation
- Registers:
  - `pc`
  - FSM state
  - one-entry skid buffer (instr, pc, full)
  - pending redirect (`redir_pend`, `redir_pc`)
  - IF/ID outputs
- FSM states: `S_IDLE`, `S_FETCH`, `S_HOLD`.
- `S_IDLE`: entered on reset; `imem_req`=0; goes to `S_FETCH` next cycle.
- `S_FETCH`: `imem_req`=1, `imem_addr_F`=`pc`. The address never changes before ack.
  - Redirect (`PCSrc_F`) without ack: latch `redir_pend`=1, `redir_pc`=`PCBranch_F`. A later redirect overwrites the earlier one.
  - Ack with a redirect this cycle or `redir_pend`: discard `imem_rdata`. Set `pc` ← current-cycle target if `PCSrc_F`, else `redir_pc`. Clear `redir_pend`. Stay in `S_FETCH`.
  - Ack with IF/ID free (`valid_D`=0 or `stall_D`=0): load `instr_D`/`pc_D`, set `valid_D`=1, `pc` ← `pc`+4 (mod 2^N). Stay in `S_FETCH`.
  - Ack with IF/ID occupied and stalled: write the skid buffer, `pc` ← `pc`+4, go to `S_HOLD`.
- `S_HOLD`: `imem_req`=0.
  - When `stall_D`=0: move skid → IF/ID and go to `S_FETCH`.
- Squash: `PCSrc_F`=1 in any state clears `valid_D` and the skid buffer next edge. In `S_HOLD` it also sets `pc` ← `PCBranch_F` and goes to `S_FETCH`.
- `valid_D` drops to 0 when `stall_D`=0 and no new instruction is loaded.
- PC arithmetic is unsigned N-bit wrap; the increment is the constant 4.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr_F`=`RESET_PC`
  - `instr_D`=0, `pc_D`=0, `valid_D`=0
  - skid empty, `redir_pend`=0, state `S_IDLE`
- Reset asserted mid-transaction abandons the outstanding request. The first `imem_req` appears two cycles after the reset edge is sampled high, followed by low.
- Latency: IF/ID is updated on the edge at the end of the ack cycle.
- Throughput: one instruction per cycle with zero-wait memory (ack same cycle as req).
- Redirect-to-request: the target address appears on `imem_addr_F` the cycle after redirect, or after the ack if a request is outstanding.
- `imem_req` is never deasserted before ack while in `S_FETCH`.

## Configuration
- `FETCH_EXC_EN` defined:
  - Port `exc_F` exists.
  - `exc_F`=1 acts as a redirect to `EXC_VECTOR` with priority over `PCSrc_F` on the same cycle.
  - It uses the same pending/squash mechanism.
- Not defined: no `exc_F` port; `EXC_VECTOR` is ignored; behaviour is identical to `exc_F`≡0.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t`
  - `INSTR_W`=32
  - `PC_INC`=4
- Sub-module `fetch_skid`: one-entry holding register (load, drain, flush, full flag), parameterised on N.
- The increment reuses the existing adder module.

## Test plan
- Zero-wait memory, reset release, no stalls → `imem_addr_F` sequence 0,4,8,12 on consecutive cycles; `valid_D`=1 from the cycle after the first ack; `pc_D` lags by one.
- Ack delayed 3 cycles at addr 8 → `imem_addr_F` held at 8 for all 3 cycles; `pc_D`=8 the cycle after ack.
- `stall_D`=1 for 4 cycles while fetching 0x10 → skid holds 0x10, `imem_req`=0 in `S_HOLD`; after release, `pc_D`=0x10 then 0x14, with no instruction lost or duplicated.
- `PCSrc_F`=1 with `PCBranch_F`=0x100 while ack for 0x20 is pending → 0x20 data discarded, next `imem_addr_F`=0x100, `valid_D`=0 for the squashed slot.
- Reset pulsed mid-wait and during `S_HOLD` → all outputs at reset values; first request afterwards to `RESET_PC`.
- With `FETCH_EXC_EN`: `exc_F` and `PCSrc_F` in the same cycle, `EXC_VECTOR`='h80, `PCBranch_F`='h200 → next address 'h80.
